// File: rtl/uart_cmd_arb_if.sv
// Signal bundle between uart_cmd_arb, its two requesters and the UART command engine.
// The arbiter attaches through the slave modport; the surrounding logic uses master.
interface uart_cmd_arb_if #(
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8
);
    logic [CMD_WIDTH-1:0]  req0_cmd;
    logic                  req0_vld;
    logic                  req0_rdy;
    logic                  req0_resp_vld;
    logic [READ_WIDTH-1:0] req0_resp_data;
    logic                  req0_resp_err;
    logic [CMD_WIDTH-1:0]  req1_cmd;
    logic                  req1_vld;
    logic                  req1_rdy;
    logic                  req1_resp_vld;
    logic [READ_WIDTH-1:0] req1_resp_data;
    logic                  req1_resp_err;
    logic [CMD_WIDTH-1:0]  cmd_in;
    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic                  read_rdy;
    logic [READ_WIDTH-1:0] read_data;
    logic                  busy;
    logic                  grant;

    modport slave (
        input  req0_cmd, req0_vld, req1_cmd, req1_vld, cmd_rdy, read_rdy, read_data,
        output req0_rdy, req0_resp_vld, req0_resp_data, req0_resp_err,
        output req1_rdy, req1_resp_vld, req1_resp_data, req1_resp_err,
        output cmd_in, cmd_vld, busy, grant
    );

    modport master (
        output req0_cmd, req0_vld, req1_cmd, req1_vld, cmd_rdy, read_rdy, read_data,
        input  req0_rdy, req0_resp_vld, req0_resp_data, req0_resp_err,
        input  req1_rdy, req1_resp_vld, req1_resp_data, req1_resp_err,
        input  cmd_in, cmd_vld, busy, grant
    );
endinterface

// File: rtl/uart_cmd_arb.sv
// Round-robin arbiter feeding two requesters' commands into one UART command engine.
// Define UART_ARB_TIMEOUT_EN to answer unanswered reads with an error after TIMEOUT cycles.
module uart_cmd_arb #(
    parameter int          CMD_WIDTH  = 16,
    parameter int          READ_WIDTH = 8,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input logic           clk,
    input logic           rst_n,
    uart_cmd_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t                state;
    logic [CMD_WIDTH-1:0]  cmd_buf;
    logic [READ_WIDTH-1:0] resp_data;
    logic                  resp_vld0;
    logic                  resp_vld1;
    logic                  cmd_vld;
    logic                  busy;
    logic                  grant;
    logic                  last_grant;
    logic                  any_vld;
    logic                  pick;

    assign any_vld = bus.req0_vld | bus.req1_vld;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        if (bus.req0_vld && bus.req1_vld) begin
            pick = ~last_grant;
        end else begin
            pick = bus.req1_vld;
        end
    end

    assign bus.req0_rdy       = (state == IDLE) && any_vld && !pick;
    assign bus.req1_rdy       = (state == IDLE) && any_vld && pick;
    assign bus.cmd_in         = cmd_buf;
    assign bus.cmd_vld        = cmd_vld;
    assign bus.busy           = busy;
    assign bus.grant          = grant;
    assign bus.req0_resp_vld  = resp_vld0;
    assign bus.req1_resp_vld  = resp_vld1;
    assign bus.req0_resp_data = resp_data;
    assign bus.req1_resp_data = resp_data;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] rd_timer;
    logic        resp_err;
    logic        expired;

    // rd_timer counts WAIT_RD cycles already spent; the transfer cycle plus the
    // current one make up the other two, so the response lands TIMEOUT cycles after transfer.
    assign expired           = ({1'b0, rd_timer} + 17'd2) >= {1'b0, TIMEOUT};
    assign bus.req0_resp_err = resp_err;
    assign bus.req1_resp_err = resp_err;
`else
    localparam logic [15:0] timeout_unused = TIMEOUT;

    assign bus.req0_resp_err = 1'b0;
    assign bus.req1_resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_buf    <= '0;
            resp_data  <= '0;
            resp_vld0  <= 1'b0;
            resp_vld1  <= 1'b0;
            cmd_vld    <= 1'b0;
            busy       <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            rd_timer   <= '0;
            resp_err   <= 1'b0;
`endif
        end else begin
            resp_vld0 <= 1'b0;
            resp_vld1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        cmd_buf    <= pick ? bus.req1_cmd : bus.req0_cmd;
                        grant      <= pick;
                        last_grant <= pick;
                        cmd_vld    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_rdy) begin
                        cmd_vld <= 1'b0;
                        if (cmd_buf[CMD_WIDTH-1]) begin
                            state <= WAIT_RD;
`ifdef UART_ARB_TIMEOUT_EN
                            rd_timer <= '0;
`endif
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                WAIT_RD: begin
                    if (bus.read_rdy) begin
                        resp_data <= bus.read_data;
                        resp_vld0 <= ~grant;
                        resp_vld1 <= grant;
                        state     <= RESP;
`ifdef UART_ARB_TIMEOUT_EN
                        resp_err  <= 1'b0;
                    end else if (expired) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        resp_vld0 <= ~grant;
                        resp_vld1 <= grant;
                        state     <= RESP;
                    end else begin
                        rd_timer <= rd_timer + 16'd1;
`endif
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_arb.sv
// Directed bench for uart_cmd_arb: each transaction is expanded into a per-cycle
// timeline of expected outputs, compared every cycle, plus literal spot checks.
module tb_uart_cmd_arb;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    uart_cmd_arb_if #(.CMD_WIDTH(16), .READ_WIDTH(8)) bus ();

    uart_cmd_arb #(
        .CMD_WIDTH (16),
        .READ_WIDTH(8),
        .TIMEOUT   (16'(TMO))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        e_busy, e_cmd_vld, e_rdy0, e_rdy1, e_rvld0, e_rvld1, e_grant, e_rerr;
    logic [15:0] e_cmd_in;
    logic [7:0]  e_rdata;
    int          m_last;
    logic        m_grant;
    logic [15:0] m_cmd;

    int          vld_cycles = 0;
    int          xfer_cyc = 0;
    int          resp_cyc = 0;
    int          resp0_cnt = 0;
    int          resp1_cnt = 0;
    logic [7:0]  seen_data = '0;
    logic        seen_err = 1'b0;
    logic        seen_grant = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleExpect();
        e_busy    = 1'b0;
        e_cmd_vld = 1'b0;
        e_rdy0    = 1'b0;
        e_rdy1    = 1'b0;
        e_rvld0   = 1'b0;
        e_rvld1   = 1'b0;
        e_rerr    = 1'b0;
        e_rdata   = '0;
        e_cmd_in  = m_cmd;
        e_grant   = m_grant;
    endtask

    task automatic modelReset();
        m_last  = 1;
        m_grant = 1'b0;
        m_cmd   = '0;
        idleExpect();
    endtask

    // One complete transaction starting in IDLE. rd_delay counts cycles from
    // command transfer to read_rdy; rst_at > 0 pulls reset in that WAIT_RD cycle.
    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic [15:0] c0, input logic [15:0] c1,
                                 input int issue_wait, input int rd_delay,
                                 input logic [7:0] rd_val, input int rst_at);
        int          w;
        logic [15:0] c;
        int          resp_at;
        logic        tmo;
        step();
        bus.req0_vld = v0;
        bus.req1_vld = v1;
        bus.req0_cmd = c0;
        bus.req1_cmd = c1;
        bus.cmd_rdy  = (issue_wait == 0);
        idleExpect();
        if (!v0 && !v1) return;
        if (v0 && v1) w = 1 - m_last;
        else          w = v1 ? 1 : 0;
        c       = (w == 1) ? c1 : c0;
        e_rdy0  = (w == 0);
        e_rdy1  = (w == 1);
        m_cmd   = c;
        m_grant = w[0];
        m_last  = w;
        for (int k = 0; k <= issue_wait; k++) begin
            step();
            bus.req0_vld = 1'b0;
            bus.req1_vld = 1'b0;
            bus.cmd_rdy  = (k == issue_wait);
            idleExpect();
            e_busy    = 1'b1;
            e_cmd_vld = 1'b1;
        end
        if (!c[15]) begin
            step();
            bus.cmd_rdy = 1'b0;
            idleExpect();
            return;
        end
        tmo     = 1'b0;
        resp_at = rd_delay + 1;
`ifdef UART_ARB_TIMEOUT_EN
        if (rd_delay < 1 || rd_delay >= TMO) begin
            tmo     = 1'b1;
            resp_at = TMO;
        end
`endif
        for (int d = 1; d < resp_at; d++) begin
            step();
            bus.cmd_rdy   = 1'b0;
            bus.read_rdy  = !tmo && (d == rd_delay);
            bus.read_data = bus.read_rdy ? rd_val : ~rd_val;
            idleExpect();
            e_busy = 1'b1;
            if (d == rst_at) begin
                #2;
                rst_n = 1'b0;
                modelReset();
                #1;
                checkOutput("rst_busy", 32'(bus.busy), 32'd0);
                checkOutput("rst_cmd_vld", 32'(bus.cmd_vld), 32'd0);
                checkOutput("rst_grant", 32'(bus.grant), 32'd0);
                checkOutput("rst_cmd_in", 32'(bus.cmd_in), 32'd0);
                return;
            end
        end
        step();
        bus.read_rdy = 1'b0;
        idleExpect();
        e_busy  = 1'b1;
        e_rvld0 = (w == 0);
        e_rvld1 = (w == 1);
        e_rdata = tmo ? 8'h00 : rd_val;
        e_rerr  = tmo;
        step();
        idleExpect();
    endtask

    task automatic idleCycles(input int n, input int stray_at);
        for (int i = 0; i < n; i++) begin
            step();
            bus.read_rdy  = (i == stray_at);
            bus.read_data = 8'hEE;
            idleExpect();
        end
    endtask

    // Per-cycle comparison against the timeline model, plus event bookkeeping.
    always @(negedge clk) begin
        checkOutput("busy", 32'(bus.busy), 32'(e_busy));
        checkOutput("cmd_vld", 32'(bus.cmd_vld), 32'(e_cmd_vld));
        checkOutput("cmd_in", 32'(bus.cmd_in), 32'(e_cmd_in));
        checkOutput("req0_rdy", 32'(bus.req0_rdy), 32'(e_rdy0));
        checkOutput("req1_rdy", 32'(bus.req1_rdy), 32'(e_rdy1));
        checkOutput("req0_resp_vld", 32'(bus.req0_resp_vld), 32'(e_rvld0));
        checkOutput("req1_resp_vld", 32'(bus.req1_resp_vld), 32'(e_rvld1));
        checkOutput("grant", 32'(bus.grant), 32'(e_grant));
        if (e_rvld0) begin
            checkOutput("req0_resp_data", 32'(bus.req0_resp_data), 32'(e_rdata));
            checkOutput("req0_resp_err", 32'(bus.req0_resp_err), 32'(e_rerr));
        end
        if (e_rvld1) begin
            checkOutput("req1_resp_data", 32'(bus.req1_resp_data), 32'(e_rdata));
            checkOutput("req1_resp_err", 32'(bus.req1_resp_err), 32'(e_rerr));
        end
        if (bus.cmd_vld) vld_cycles++;
        if (bus.cmd_vld && bus.cmd_rdy) xfer_cyc = cyc;
        if (bus.req0_resp_vld || bus.req1_resp_vld) begin
            resp_cyc   = cyc;
            seen_grant = bus.grant;
            seen_data  = bus.req0_resp_vld ? bus.req0_resp_data : bus.req1_resp_data;
            seen_err   = bus.req0_resp_vld ? bus.req0_resp_err : bus.req1_resp_err;
        end
        if (bus.req0_resp_vld) resp0_cnt++;
        if (bus.req1_resp_vld) resp1_cnt++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order_want[4];
        int b;
        order_want = '{0, 1, 0, 1};
        rst_n         = 1'b0;
        bus.req0_vld  = 1'b0;
        bus.req1_vld  = 1'b0;
        bus.req0_cmd  = '0;
        bus.req1_cmd  = '0;
        bus.cmd_rdy   = 1'b0;
        bus.read_rdy  = 1'b0;
        bus.read_data = '0;
        modelReset();
        repeat (3) step();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(256 + i), 16'(512 + i), 0, 0, 8'h00, 0);
            checkOutput("tie_order", 32'(bus.grant), 32'(order_want[i]));
        end

        b = vld_cycles;
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000, 0, 0, 8'h00, 0);
        checkOutput("wr_cmd_in", 32'(bus.cmd_in), 32'h0012);
        checkOutput("wr_vld_cycles", 32'(vld_cycles - b), 32'd1);
        checkOutput("wr_busy_low", 32'(bus.busy), 32'd0);
        checkOutput("wr_no_resp", 32'(resp0_cnt + resp1_cnt), 32'd0);

        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h8034, 0, 5, 8'hA5, 0);
        checkOutput("rd_resp_count", 32'(resp1_cnt), 32'd1);
        checkOutput("rd_data", 32'(seen_data), 32'hA5);
        checkOutput("rd_err", 32'(seen_err), 32'd0);
        checkOutput("rd_grant", 32'(seen_grant), 32'd1);
        checkOutput("rd_latency", 32'(resp_cyc - xfer_cyc), 32'd6);

        b = vld_cycles;
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000, 10, 0, 8'h00, 0);
        checkOutput("stall_vld_cycles", 32'(vld_cycles - b), 32'd11);
        checkOutput("stall_cmd_in", 32'(bus.cmd_in), 32'h1234);

        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0456, 0, 0, 8'h00, 0);
        checkOutput("single_req1_a", 32'(bus.grant), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0457, 0, 0, 8'h00, 0);
        checkOutput("single_req1_b", 32'(bus.grant), 32'd1);
        applyStimulus(1'b1, 1'b1, 16'h0458, 16'h0459, 0, 0, 8'h00, 0);
        checkOutput("tie_after_single", 32'(bus.grant), 32'd0);

        applyStimulus(1'b1, 1'b0, 16'hC03C, 16'h0000, 3, 1, 8'h3C, 0);
        checkOutput("rd_fast_data", 32'(seen_data), 32'h3C);
        checkOutput("rd_fast_latency", 32'(resp_cyc - xfer_cyc), 32'd2);

        b = resp0_cnt + resp1_cnt;
        idleCycles(4, 1);
        checkOutput("stray_ignored", 32'(resp0_cnt + resp1_cnt - b), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        applyStimulus(1'b1, 1'b0, 16'h80AA, 16'h0000, 0, -1, 8'h00, 0);
        checkOutput("tmo_latency", 32'(resp_cyc - xfer_cyc), 32'(TMO));
        checkOutput("tmo_data", 32'(seen_data), 32'h00);
        checkOutput("tmo_err", 32'(seen_err), 32'd1);
        b = resp0_cnt + resp1_cnt;
        idleCycles(3, 0);
        checkOutput("tmo_stray_ignored", 32'(resp0_cnt + resp1_cnt - b), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h80BB, 0, TMO - 1, 8'h77, 0);
        checkOutput("tmo_edge_latency", 32'(resp_cyc - xfer_cyc), 32'(TMO));
        checkOutput("tmo_edge_data", 32'(seen_data), 32'h77);
        checkOutput("tmo_edge_err", 32'(seen_err), 32'd0);
`endif

        b = resp0_cnt + resp1_cnt;
        applyStimulus(1'b1, 1'b0, 16'h8055, 16'h0000, 0, 8, 8'h66, 3);
        step();
        step();
        rst_n = 1'b1;
        idleCycles(6, 2);
        checkOutput("rst_no_resp", 32'(resp0_cnt + resp1_cnt - b), 32'd0);
        applyStimulus(1'b1, 1'b1, 16'h0777, 16'h0888, 0, 0, 8'h00, 0);
        checkOutput("rst_tie_req0", 32'(bus.grant), 32'd0);
        idleCycles(2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
